// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 3-stage RV32I pipeline: stalls, flushes, MW->DE forwarding,
// and a data-memory wait FSM with timeout. Optional perf counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int PERF_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr_de,
    input  logic [31:0]       instr_mw,
    input  logic              reg_wr_mw,
    input  logic              mem_rd_mw,
    input  logic              mem_wr_mw,
    input  logic              br_taken_de,
    input  logic              dmem_ready,
    output logic              stall_fd,
    output logic              flush_fd,
    output logic              stall_em,
    output logic              flush_em,
    output logic              fwd_rs1,
    output logic              fwd_rs2,
    output logic              reg_wr_ok,
    output logic              halted,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

    logic [1:0]    fsm_q, fsm_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic [6:0] opcode_de;
    logic [4:0] rs1_de, rs2_de, rd_mw;
    logic       rs1_used, rs2_used, mw_writes_reg;
    logic       mem_stall, active;
    logic       unused_instr_bits;

    assign opcode_de = instr_de[6:0];
    assign rs1_de    = instr_de[19:15];
    assign rs2_de    = instr_de[24:20];
    assign rd_mw     = instr_mw[11:7];
    assign unused_instr_bits = ^{instr_de[31:25], instr_de[14:7], instr_mw[31:12], instr_mw[6:0]};

    assign rs1_used = (opcode_de != OP_LUI) && (opcode_de != OP_AUIPC) && (opcode_de != OP_JAL);
    assign rs2_used = (opcode_de == OP_REG) || (opcode_de == OP_STORE) || (opcode_de == OP_BRANCH);

    // Forwarding ignores FSM state; x0 is never a real producer.
    assign mw_writes_reg = reg_wr_mw && (rd_mw != 5'd0);
    assign fwd_rs1 = mw_writes_reg && rs1_used && (rd_mw == rs1_de);
    assign fwd_rs2 = mw_writes_reg && rs2_used && (rd_mw == rs2_de);

    assign active    = (fsm_q == ST_RUN) || (fsm_q == ST_MEM_WAIT);
    assign mem_stall = active && (mem_rd_mw || mem_wr_mw) && !dmem_ready;

    // ERR holds fetch and drains NOPs into MW so nothing further commits.
    assign stall_fd  = active ? mem_stall : 1'b1;
    assign stall_em  = mem_stall;
    assign flush_fd  = active && br_taken_de && !mem_stall;
    assign flush_em  = !active;
    assign reg_wr_ok = active && reg_wr_mw && !mem_stall;
    assign halted    = !active;

    always_comb begin
        fsm_d      = fsm_q;
        wait_cnt_d = wait_cnt_q;
        case (fsm_q)
            ST_RUN: begin
                if (mem_stall) begin
                    fsm_d      = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                // Ready wins over the timeout in the last allowed stalled cycle.
                if (dmem_ready) begin
                    fsm_d      = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fsm_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            default: fsm_d = ST_ERR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q      <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (mem_stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_fd && !(&flush_cnt_q))  flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
